// File: rtl/iomem_button_ctrl.sv
// Debounced push-button peripheral on the PicoSoC iomem bus.
// Regs: 0x00 STATE, 0x04 EVENT (W1C), 0x08 IRQ_EN, 0x0C RAW.
//
// Ports:
//   clk, reset (async, active high)
//   iomem_valid/ready/wstrb/addr/wdata/rdata : PicoSoC iomem slave
//   buttons_n[7:0] : raw active-low pads
//   irq            : registered level interrupt
// Optional feature macro: BUTTON_RELEASE_EVT_EN
//   defined   -> release edges set EVENT[15:8], masked by IRQ_EN[15:8]
//   undefined -> EVENT[15:8] and IRQ_EN[15:8] are fixed at 0
module iomem_button_ctrl #(
  parameter logic [7:0] BASE_ADDR       = 8'h04,
  parameter int         DEBOUNCE_CYCLES = 16000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic [7:0]  buttons_n,
  output logic        irq
);

  localparam logic [15:0] CNT_MAX =
    16'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_RELEASE_EVT_EN
  localparam logic [15:0] EVT_MASK = 16'hFFFF;
`else
  localparam logic [15:0] EVT_MASK = 16'h00FF;
`endif

  logic [7:0]       sync1;
  logic [7:0]       sync2;
  logic [7:0]       stable;
  logic [7:0][15:0] cnt;
  logic [7:0]       done;
  logic [7:0]       rise;
  logic [15:0]      evt;
  logic [15:0]      evt_set;
  logic [15:0]      evt_clr;
  logic [15:0]      irq_en;
  logic [15:0]      byte_mask;
  logic [7:0]       offset;
  logic             hit;
  logic             accept;
  logic             is_wr;
  logic             wr_evt;
  logic             wr_en;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign unused_bits = ^{iomem_addr[23:8],
                         iomem_wdata[31:16],
                         iomem_wstrb[3:2]};

  assign offset = iomem_addr[7:0];
  assign hit    = iomem_addr[31:24] == BASE_ADDR;
  // No new request in the ready cycle, so
  // a held valid is not served twice.
  assign accept = iomem_valid && !iomem_ready && hit;
  assign is_wr  = |iomem_wstrb;
  assign wr_evt = accept && is_wr && offset == 8'h04;
  assign wr_en  = accept && is_wr && offset == 8'h08;

  assign byte_mask = {{8{iomem_wstrb[1]}},
                      {8{iomem_wstrb[0]}}};

  // done[i]: the mismatch has held long enough,
  // stable[i] flips on this edge.
  always_comb begin
    done = '0;
    for (int i = 0; i < 8; i++) begin
      done[i] = (sync2[i] != stable[i]) &&
                (cnt[i] == CNT_MAX);
    end
  end

  assign rise = done & sync2;

`ifdef BUTTON_RELEASE_EVT_EN
  logic [7:0] fall;
  assign fall    = done & ~sync2;
  assign evt_set = {fall, rise};
`else
  assign evt_set = {8'h00, rise};
`endif

  assign evt_clr = wr_evt
    ? (iomem_wdata[15:0] & byte_mask)
    : 16'h0000;

  always_comb begin
    rd_mux = '0;
    case (offset)
      8'h00:   rd_mux = {24'h0, stable};
      8'h04:   rd_mux = {16'h0, evt};
      8'h08:   rd_mux = {16'h0, irq_en};
      8'h0C:   rd_mux = {24'h0, sync2};
      default: rd_mux = '0;
    endcase
  end

  // Inverted at the pad so 1 = pressed inside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~buttons_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == stable[i] || done[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 16'd1;
      end
      stable <= stable ^ done;
    end
  end

  // Set is OR-ed after the clear: set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt    <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      evt <= ((evt & ~evt_clr) | evt_set)
             & EVT_MASK;
      if (wr_en)
        irq_en <= ((irq_en & ~byte_mask) |
                   (iomem_wdata[15:0] & byte_mask))
                  & EVT_MASK;
      irq <= |(evt & irq_en);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= accept;
      if (accept)
        iomem_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_iomem_button_ctrl.sv
// Scoreboard bench for iomem_button_ctrl
// with DEBOUNCE_CYCLES = 4.
module tb_iomem_button_ctrl;

  localparam logic [7:0] BASE = 8'h04;

`ifdef BUTTON_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic [7:0]  buttons_n = 8'hFF;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        rd;
    logic [7:0]  off;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  iomem_button_ctrl #(
    .BASE_ADDR(BASE),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .buttons_n(buttons_n),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h",
               nm, got, exp);
    end
  endtask

  // Monitor: every ready pulse must match a
  // queued transfer; reads compare rdata.
  always @(negedge clk) begin
    if (!reset && iomem_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready t=%0t",
                 $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.rd) begin
          total++;
          if (iomem_rdata !== e.val) begin
            bad++;
            $display("FAIL rd_%h got=%h exp=%h",
                     e.off, iomem_rdata, e.val);
          end
        end
      end
    end
  end

  task automatic bus(input logic [31:0] addr,
                     input logic [31:0] wd,
                     input logic [3:0]  ws,
                     input logic [31:0] exp,
                     input bit          hit);
    bit got;
    got = 1'b0;
    if (hit)
      sb.push_back('{rd: (ws == 4'd0),
                     off: addr[7:0],
                     val: exp});
    iomem_addr  = addr;
    iomem_wdata = wd;
    iomem_wstrb = ws;
    iomem_valid = 1'b1;
    for (int k = 0; k < 6 && !got; k++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) got = 1'b1;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = '0;
    chk("ack", 32'(got), 32'(hit));
  endtask

  task automatic rd(input logic [7:0] off,
                    input logic [31:0] exp);
    bus({BASE, 16'h0, off}, '0, 4'd0, exp, 1'b1);
  endtask

  task automatic wr(input logic [7:0] off,
                    input logic [31:0] d,
                    input logic [3:0] s);
    bus({BASE, 16'h0, off}, d, s, '0, 1'b1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and idle
    cyc(3);
    reset = 1'b0;
    #1;
    chk("rst_ready", 32'(iomem_ready), 0);
    chk("rst_rdata", iomem_rdata, 0);
    chk("rst_irq", 32'(irq), 0);
    cyc(4);
    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);
    rd(8'h08, 32'h0);
    rd(8'h0C, 32'h0);
    chk("idle_irq", 32'(irq), 0);

    // Glitch: 3-cycle pulse on bit 0,
    // RAW sampled mid-pulse.
    buttons_n = 8'hFE;
    cyc(2);
    rd(8'h0C, 32'h01);
    buttons_n = 8'hFF;
    cyc(10);
    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);

    // Clean press on bit 3 with IRQ_EN=0x08
    wr(8'h08, 32'h08, 4'hF);
    cyc(2);
    buttons_n = 8'hF7;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k >= 6)
        chk($sformatf("irq_e%0d", k),
            32'(irq), 32'(k == 7));
    end
    rd(8'h00, 32'h08);
    rd(8'h04, 32'h08);
    rd(8'h0C, 32'h08);

    // W1C
    buttons_n = 8'hF6;
    cyc(10);
    rd(8'h04, 32'h09);
    wr(8'h04, 32'h01, 4'b0001);
    rd(8'h04, 32'h08);
    chk("irq_hold", 32'(irq), 1);

    // Collision: clear lands on the edge
    // stable[0] rises.
    buttons_n = 8'hF7;
    cyc(10);
    buttons_n = 8'hF6;
    cyc(5);
    wr(8'h04, 32'h01, 4'b0001);
    rd(8'h04, REL ? 32'h109 : 32'h09);

    // Strobes and decode
    wr(8'h08, 32'hFFFF_FFFF, 4'b0001);
    rd(8'h08, 32'hFF);
    bus(32'h0300_0008, '0, 4'd0, '0, 1'b0);
    chk("miss_rdata", iomem_rdata, 32'hFF);
    rd(8'h10, 32'h0);
    cyc(3);

    // irq falls one cycle after mask write
    chk("irq_pre", 32'(irq), 1);
    wr(8'h08, 32'h0, 4'hF);
    chk("irq_fall0", 32'(irq), 1);
    cyc(1);
    chk("irq_fall1", 32'(irq), 0);

    // Release events on bit 2
    buttons_n = 8'hFF;
    cyc(10);
    wr(8'h04, 32'hFFFF, 4'b0011);
    rd(8'h04, 32'h0);
    buttons_n = 8'hFB;
    cyc(10);
    buttons_n = 8'hFF;
    cyc(10);
    rd(8'h04, REL ? 32'h0404 : 32'h0004);

    // Reset mid-count and mid-transfer
    wr(8'h08, 32'h04, 4'hF);
    buttons_n = 8'hDF;
    cyc(4);
    iomem_addr  = {BASE, 24'h0};
    iomem_valid = 1'b1;
    reset = 1'b1;
    cyc(2);
    iomem_valid = 1'b0;
    buttons_n = 8'hFF;
    reset = 1'b0;
    cyc(10);
    chk("rst2_irq", 32'(irq), 0);
    rd(8'h00, 32'h0);
    rd(8'h04, 32'h0);
    rd(8'h08, 32'h0);

    for (int k = 0; k < 10 && sb.size() != 0; k++)
      cyc(1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
